// File: rtl/slip_frame_rx_if.sv
// Byte-stream input, frame read port and error pulses of the SLIP frame receiver.
// Carries o_err_csum only when SLIP_RX_CHECKSUM_EN is defined.
interface slip_frame_rx_if #(
    parameter int unsigned MAX_LEN = 64
);
    localparam int unsigned AW = $clog2(MAX_LEN);

    logic [7:0]    i_byte;
    logic          i_byte_valid;
    logic          o_frame_ready;
    logic [AW:0]   o_frame_len;
    logic [AW-1:0] i_rd_addr;
    logic [7:0]    o_rd_data;
    logic          i_frame_ack;
    logic          o_err_ovf;
    logic          o_err_esc;
    logic          o_err_busy;
`ifdef SLIP_RX_CHECKSUM_EN
    logic          o_err_csum;

    modport master (
        output i_byte, i_byte_valid, i_rd_addr, i_frame_ack,
        input  o_frame_ready, o_frame_len, o_rd_data, o_err_ovf, o_err_esc, o_err_busy, o_err_csum
    );
    modport slave (
        input  i_byte, i_byte_valid, i_rd_addr, i_frame_ack,
        output o_frame_ready, o_frame_len, o_rd_data, o_err_ovf, o_err_esc, o_err_busy, o_err_csum
    );
`else
    modport master (
        output i_byte, i_byte_valid, i_rd_addr, i_frame_ack,
        input  o_frame_ready, o_frame_len, o_rd_data, o_err_ovf, o_err_esc, o_err_busy
    );
    modport slave (
        input  i_byte, i_byte_valid, i_rd_addr, i_frame_ack,
        output o_frame_ready, o_frame_len, o_rd_data, o_err_ovf, o_err_esc, o_err_busy
    );
`endif
endinterface

// File: rtl/slip_frame_rx.sv
// SLIP frame receiver: strips framing/escapes into a frame buffer read by the host.
// Optional trailing-checksum verification is enabled with SLIP_RX_CHECKSUM_EN.
module slip_frame_rx #(
    parameter int unsigned MAX_LEN = 64
) (
    input  logic           clk,
    input  logic           reset,
    slip_frame_rx_if.slave bus
);
    localparam int unsigned AW = $clog2(MAX_LEN);
    localparam int unsigned LW = AW + 1;
    localparam logic [7:0] SLIP_END     = 8'hC0;
    localparam logic [7:0] SLIP_ESC     = 8'hDB;
    localparam logic [7:0] SLIP_ESC_END = 8'hDC;
    localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

    typedef enum logic [1:0] {S_RECV, S_ESCAPED, S_DISCARD, S_READY} state_e;

    state_e        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] frame_len_q, frame_len_d;
    logic          mid_drop_q, mid_drop_d;
    logic          frame_ready_q, frame_ready_d;
    logic          err_ovf_q, err_ovf_d;
    logic          err_esc_q, err_esc_d;
    logic          err_busy_q, err_busy_d;
    logic [7:0]    rd_data_q;
`ifdef SLIP_RX_CHECKSUM_EN
    logic [7:0]    sum_q, sum_d;
    logic          err_csum_q, err_csum_d;
`endif

    logic          store_req;
    logic [7:0]    store_data;
    logic          drop_flag;
    logic          wr_en;
    logic [7:0]    mem [MAX_LEN];

    // Next-state decode; decoded payload bytes funnel through one overflow-checked store.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        frame_len_d = frame_len_q;
        mid_drop_d  = mid_drop_q;
        err_ovf_d   = 1'b0;
        err_esc_d   = 1'b0;
        err_busy_d  = 1'b0;
        store_req   = 1'b0;
        store_data  = bus.i_byte;
        drop_flag   = mid_drop_q;
        wr_en       = 1'b0;
`ifdef SLIP_RX_CHECKSUM_EN
        sum_d       = sum_q;
        err_csum_d  = 1'b0;
`endif
        if (state_q == S_READY) begin
            if (bus.i_byte_valid) begin
                err_busy_d = 1'b1;
                drop_flag  = (bus.i_byte != SLIP_END);
            end
            mid_drop_d = drop_flag;
            if (bus.i_frame_ack) begin
                len_d      = '0;
                mid_drop_d = 1'b0;
                state_d    = drop_flag ? S_DISCARD : S_RECV;
`ifdef SLIP_RX_CHECKSUM_EN
                sum_d      = '0;
`endif
            end
        end else if (bus.i_byte_valid) begin
            case (state_q)
                S_RECV: begin
                    if (bus.i_byte == SLIP_END) begin
                        if (len_q != '0) begin
`ifdef SLIP_RX_CHECKSUM_EN
                            if (len_q < LW'(2) || sum_q != 8'h00) begin
                                err_csum_d = 1'b1;
                                len_d      = '0;
                                sum_d      = '0;
                            end else begin
                                state_d     = S_READY;
                                frame_len_d = len_q - LW'(1);
                            end
`else
                            state_d     = S_READY;
                            frame_len_d = len_q;
`endif
                        end
                    end else if (bus.i_byte == SLIP_ESC) begin
                        state_d = S_ESCAPED;
                    end else begin
                        store_req = 1'b1;
                    end
                end
                S_ESCAPED: begin
                    if (bus.i_byte == SLIP_ESC_END || bus.i_byte == SLIP_ESC_ESC) begin
                        store_req  = 1'b1;
                        store_data = (bus.i_byte == SLIP_ESC_END) ? SLIP_END : SLIP_ESC;
                        state_d    = S_RECV;
                    end else if (bus.i_byte == SLIP_END) begin
                        err_esc_d = 1'b1;
                        len_d     = '0;
                        state_d   = S_RECV;
`ifdef SLIP_RX_CHECKSUM_EN
                        sum_d     = '0;
`endif
                    end else begin
                        err_esc_d = 1'b1;
                        state_d   = S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (bus.i_byte == SLIP_END) begin
                        len_d   = '0;
                        state_d = S_RECV;
`ifdef SLIP_RX_CHECKSUM_EN
                        sum_d   = '0;
`endif
                    end
                end
                default: ;
            endcase

            if (store_req) begin
                if (len_q == LW'(MAX_LEN)) begin
                    err_ovf_d = 1'b1;
                    state_d   = S_DISCARD;
                end else begin
                    wr_en = 1'b1;
                    len_d = len_q + LW'(1);
`ifdef SLIP_RX_CHECKSUM_EN
                    sum_d = sum_q + store_data;
`endif
                end
            end
        end
        frame_ready_d = (state_d == S_READY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_RECV;
            len_q         <= '0;
            frame_len_q   <= '0;
            mid_drop_q    <= 1'b0;
            frame_ready_q <= 1'b0;
            err_ovf_q     <= 1'b0;
            err_esc_q     <= 1'b0;
            err_busy_q    <= 1'b0;
`ifdef SLIP_RX_CHECKSUM_EN
            sum_q         <= '0;
            err_csum_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            frame_len_q   <= frame_len_d;
            mid_drop_q    <= mid_drop_d;
            frame_ready_q <= frame_ready_d;
            err_ovf_q     <= err_ovf_d;
            err_esc_q     <= err_esc_d;
            err_busy_q    <= err_busy_d;
`ifdef SLIP_RX_CHECKSUM_EN
            sum_q         <= sum_d;
            err_csum_q    <= err_csum_d;
`endif
        end
    end

    // Single write port plus registered read port so the buffer maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[len_q[AW-1:0]] <= store_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[bus.i_rd_addr];
        end
    end

    assign bus.o_frame_ready = frame_ready_q;
    assign bus.o_frame_len   = frame_len_q;
    assign bus.o_rd_data     = rd_data_q;
    assign bus.o_err_ovf     = err_ovf_q;
    assign bus.o_err_esc     = err_esc_q;
    assign bus.o_err_busy    = err_busy_q;
`ifdef SLIP_RX_CHECKSUM_EN
    assign bus.o_err_csum    = err_csum_q;
`endif
endmodule
